row_scan_controller: RTL and testbench

//   Sequences the 3-to-8 row decoder that drives the 8-row LED display of the Game of Life board.

---
 rtl/row_scan_controller.sv | 112 +++++++++++
 tb/tb_row_scan_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/row_scan_controller.sv
// Row scan sequencer for the 8-row LED board: fetches each row's cell data over a
// req/ack handshake, lights the row for PRESCALE cycles, then blanks before the next row.
module row_scan_controller #(
    parameter int N_ROWS   = 8,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 4,
    localparam int ROW_BITS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                fetch_ack,
    output logic                fetch_req,
    output logic [ROW_BITS-1:0] fetch_row,
    output logic                row_ena,
    output logic [ROW_BITS-1:0] row_sel,
    output logic                frame_done,
    output logic                busy
);

    localparam int CNT_MAX  = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);

    localparam logic [CNT_BITS-1:0] ON_LAST    = CNT_BITS'(PRESCALE - 1);
    localparam logic [CNT_BITS-1:0] BLANK_LAST = CNT_BITS'(BLANK - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(N_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ON,
        ST_BLANK
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [ROW_BITS-1:0] sel_q, sel_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ena only matters in IDLE and at the BLANK exit, so a started row always runs to completion.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (fetch_ack) begin
                    state_d = ST_ON;
                    sel_d   = row_q;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    row_d        = (row_q == ROW_LAST) ? '0 : row_q + ROW_BITS'(1);
                    frame_done_d = (row_q == ROW_LAST);
                    state_d      = ena ? ST_FETCH : ST_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset blanks the decoder immediately.
    assign fetch_req  = (state_q == ST_FETCH);
    assign fetch_row  = row_q;
    assign row_ena    = (state_q == ST_ON);
    assign row_sel    = sel_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_row_scan_controller.sv
// Directed self-checking bench for row_scan_controller with N_ROWS=8, PRESCALE=4, BLANK=2.
module tb_row_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       fetch_ack;
    logic       fetch_req;
    logic [2:0] fetch_row;
    logic       row_ena;
    logic [2:0] row_sel;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    row_scan_controller #(
        .N_ROWS  (8),
        .PRESCALE(4),
        .BLANK   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .fetch_ack (fetch_ack),
        .fetch_req (fetch_req),
        .fetch_row (fetch_row),
        .row_ena   (row_ena),
        .row_sel   (row_sel),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic a);
        ena       = e;
        fetch_ack = a;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called on a negedge inside ON cycle 1; walks the 4 ON and 2 BLANK cycles of row r.
    task automatic runOnBlank(input int r, input int firstOn);
        for (int k = firstOn; k < 4; k++) begin
            checkOutput($sformatf("on_ena_r%0d_c%0d", r, k), row_ena, 1);
            checkOutput($sformatf("on_sel_r%0d_c%0d", r, k), row_sel, r);
            checkOutput($sformatf("on_req_r%0d_c%0d", r, k), fetch_req, 0);
            checkOutput($sformatf("on_fd_r%0d_c%0d", r, k), frame_done, 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("blank_ena_r%0d_c%0d", r, k), row_ena, 0);
            checkOutput($sformatf("blank_sel_r%0d_c%0d", r, k), row_sel, r);
            checkOutput($sformatf("blank_busy_r%0d_c%0d", r, k), busy, 1);
            checkOutput($sformatf("blank_fd_r%0d_c%0d", r, k), frame_done, 0);
            step();
        end
    endtask

    task automatic runRow(input int r, input logic fd);
        checkOutput($sformatf("fetch_req_r%0d", r), fetch_req, 1);
        checkOutput($sformatf("fetch_row_r%0d", r), fetch_row, r);
        checkOutput($sformatf("fetch_ena_r%0d", r), row_ena, 0);
        checkOutput($sformatf("frame_done_r%0d", r), frame_done, fd);
        step();
        runOnBlank(r, 0);
    endtask

    // Every-cycle invariants: row_sel stable while lit, and never lit while fetching.
    logic       prevEna = 1'b0;
    logic [2:0] prevSel = '0;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(row_ena && fetch_req)) else begin
                errors++;
                $error("[TB] FAIL ena_req_overlap observed=%0b expected=0", row_ena && fetch_req);
            end
            if (prevEna && row_ena) begin
                checks++;
                assert (row_sel === prevSel) else begin
                    errors++;
                    $error("[TB] FAIL sel_stable observed=%0h expected=%0h", row_sel, prevSel);
                end
            end
        end
        prevEna = row_ena;
        prevSel = row_sel;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("rst_fetch_req", fetch_req, 0);
        checkOutput("rst_fetch_row", fetch_row, 0);
        checkOutput("rst_row_ena", row_ena, 0);
        checkOutput("rst_row_sel", row_sel, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("idle_busy_%0d", i), busy, 0);
        end

        // Free-running scan with ack tied high: two full frames plus one row.
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_start_req", fetch_req, 0);
        step();
        for (int idx = 0; idx < 17; idx++)
            runRow(idx % 8, (idx == 8) || (idx == 16));

        runRow(1, 1'b0);
        runRow(2, 1'b0);

        // Row 3: hold ack low for 5 cycles of FETCH.
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall_req_%0d", k), fetch_req, 1);
            checkOutput($sformatf("stall_row_%0d", k), fetch_row, 3);
            checkOutput($sformatf("stall_ena_%0d", k), row_ena, 0);
            step();
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("ack_cycle_req", fetch_req, 1);
        checkOutput("ack_cycle_ena", row_ena, 0);
        step();
        runOnBlank(3, 0);

        runRow(4, 1'b0);

        // Row 5: drop ena during its 2nd ON cycle; the row must still finish.
        checkOutput("r5_fetch_row", fetch_row, 5);
        step();
        checkOutput("r5_on1_ena", row_ena, 1);
        step();
        applyStimulus(1'b0, 1'b1);
        runOnBlank(5, 1);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_row_ena", row_ena, 0);
        checkOutput("stop_fetch_req", fetch_req, 0);
        checkOutput("stop_fetch_row", fetch_row, 6);
        step();
        step();
        checkOutput("stop_busy_late", busy, 0);

        applyStimulus(1'b1, 1'b1);
        step();
        runRow(6, 1'b0);
        runRow(7, 1'b0);
        runRow(0, 1'b1);
        runRow(1, 1'b0);

        // Row 2: async reset during ON must blank immediately without a clock edge.
        checkOutput("r2_fetch_row", fetch_row, 2);
        step();
        step();
        checkOutput("r2_on_ena", row_ena, 1);
        checkOutput("r2_on_sel", row_sel, 2);
        rst = 1'b1;
        #1;
        checkOutput("async_row_ena", row_ena, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_fetch_req", fetch_req, 0);
        checkOutput("async_fetch_row", fetch_row, 0);
        checkOutput("async_row_sel", row_sel, 0);
        step();
        rst = 1'b0;
        step();
        checkOutput("post_rst_req", fetch_req, 1);
        checkOutput("post_rst_row", fetch_row, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
